// File: rtl/seg_display_scan.sv
// seg_display_scan: 8-digit multiplexed 7-segment scanner with a debounced page-select button.
// Optional leading-zero blanking is enabled by defining the LZ_BLANK_EN macro.
module seg_display_scan #(
  parameter int unsigned SCAN_DIV   = 12500,
  parameter int unsigned DB_CYCLES  = 1000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [31:0] F,
  input  logic [31:0] M_R_Data,
  input  logic [31:0] PC,
  input  logic        ZF,
  input  logic        OF,
  input  logic        page_btn,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  page,
  output logic [1:0]  flag_led
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [7:0] RST_AN  = ACTIVE_LOW ? 8'hFE : 8'h01;
  localparam logic [7:0] RST_SEG = ACTIVE_LOW ? 8'hC0 : 8'h3F;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   page_value;
  logic [1:0]    page_q, page_d;
  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_level_q, db_level_d;
  logic          adv_q, adv_d;
  logic [1:0]    flag_led_q;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_al, seg_al;
  logic [4:0]    nib_sh;
  logic [3:0]    digit_nib;

  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      4'hF:    g = 8'h8E;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

  // Page source mux feeding the frame shadow.
  always_comb begin
    page_value = 32'h0;
    case (page_q)
      2'd0:    page_value = F;
      2'd1:    page_value = M_R_Data;
      2'd2:    page_value = PC;
      2'd3:    page_value = {24'h0, 3'b000, OF, 3'b000, ZF};
      default: page_value = 32'h0;
    endcase
  end

  // Scan prescaler, digit index and frame-coherent shadow load.
  always_comb begin
    presc_d  = presc_q + PW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        shadow_d = page_value;
      end else begin
        shadow_d = shadow_q;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Debounce: accept a new level after DB_CYCLES consecutive differing samples.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    adv_d      = 1'b0;
    page_d     = page_q + {1'b0, adv_q};
    if (sync_q[1] != db_level_q) begin
      if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
        db_level_d = sync_q[1];
        adv_d      = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Digit drive computed from next-state index/shadow so an and seg move together.
  always_comb begin
    nib_sh    = {idx_d, 2'b00};
    digit_nib = shadow_d[nib_sh +: 4];
    an_al     = ~(8'h01 << idx_d);
`ifdef LZ_BLANK_EN
    if ((idx_d != 3'd0) && ((shadow_d >> nib_sh) == 32'h0)) begin
      seg_al = 8'hFF;
    end else begin
      seg_al = hex_glyph(digit_nib);
    end
`else
    seg_al = hex_glyph(digit_nib);
`endif
    an_d  = ACTIVE_LOW ? an_al : ~an_al;
    seg_d = ACTIVE_LOW ? seg_al : ~seg_al;
  end

  // State and output registers.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= 3'd0;
      shadow_q   <= 32'h0;
      page_q     <= 2'd0;
      sync_q     <= 2'b00;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      adv_q      <= 1'b0;
      flag_led_q <= 2'b00;
      an_q       <= RST_AN;
      seg_q      <= RST_SEG;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      page_q     <= page_d;
      sync_q     <= {sync_q[0], page_btn};
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      adv_q      <= adv_d;
      flag_led_q <= {OF, ZF};
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign page     = page_q;
  assign flag_led = flag_led_q;

endmodule
